// File: rtl/rst_seq_gen.sv
// Staggered multi-channel reset sequencer with software re-sequence,
// per-channel re-reset, status flags and a divided clock-enable tick.
module rst_seq_gen #(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 4,
  parameter int CNT_W       = 8,
  parameter int DIV         = 10
) (
  input  logic              CLK,
  input  logic              SRSTn,
  input  logic              SW_RST_REQ,
  input  logic [NUM_CH-1:0] CH_RST_REQ,
  output logic [NUM_CH-1:0] RSTn_OUT,
  output logic [NUM_CH-1:0] RST_OUT,
  output logic              BUSY,
  output logic              DONE,
  output logic              TICK
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int T_LAST = HOLD_CYCLES + (NUM_CH - 1) * STAGGER;

  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STG_M1  =
    CNT_W'((STAGGER > 0) ? STAGGER - 1 : 0);
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [DIV_W-1:0] DIV_M1  = DIV_W'(DIV - 1);
  localparam bit ALL_AT_ONCE = (STAGGER == 0) || (NUM_CH == 1);

  if (NUM_CH < 1) begin : g_bad_ch
    $error("rst_seq_gen: NUM_CH must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("rst_seq_gen: HOLD_CYCLES must be >= 1");
  end
  if (STAGGER < 0) begin : g_bad_stg
    $error("rst_seq_gen: STAGGER must be >= 0");
  end
  if (DIV < 1) begin : g_bad_div
    $error("rst_seq_gen: DIV must be >= 1");
  end
  if ((64'd1 << CNT_W) <= 64'(T_LAST)) begin : g_bad_cnt
    $error("rst_seq_gen: CNT_W too narrow for sequence");
  end

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [NUM_CH-1:0] rel_d;
  logic [NUM_CH-1:0] held_q, held_d;
  logic [CNT_W-1:0]  ch_cnt_q [NUM_CH];
  logic [CNT_W-1:0]  ch_cnt_d [NUM_CH];
  logic              done_d;
  logic [DIV_W-1:0]  div_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    rel_d    = RSTn_OUT;
    held_d   = held_q;
    ch_cnt_d = ch_cnt_q;

    if (SW_RST_REQ) begin
      state_d = HOLD;
      cnt_d   = '0;
      ch_d    = '0;
      rel_d   = '0;
      held_d  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_cnt_d[i] = '0;
      end
    end else begin
      unique case (state_q)
        HOLD: begin
          if (cnt_q == HOLD_M1) begin
            cnt_d = '0;
            if (ALL_AT_ONCE) begin
              rel_d   = '1;
              state_d = RUN;
            end else begin
              rel_d[0] = 1'b1;
              ch_d     = CH_W'(1);
              state_d  = RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        RELEASE: begin
          if (cnt_q == STG_M1) begin
            cnt_d       = '0;
            rel_d[ch_q] = 1'b1;
            if (ch_q == LAST_CH) begin
              state_d = RUN;
            end else begin
              ch_d = ch_q + CH_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        RUN: begin
          // Each channel re-reset runs its own hold counter.
          for (int i = 0; i < NUM_CH; i++) begin
            if (CH_RST_REQ[i]) begin
              held_d[i]   = 1'b1;
              rel_d[i]    = 1'b0;
              ch_cnt_d[i] = '0;
            end else if (held_q[i]) begin
              if (ch_cnt_q[i] == HOLD_M1) begin
                held_d[i]   = 1'b0;
                rel_d[i]    = 1'b1;
                ch_cnt_d[i] = '0;
              end else begin
                ch_cnt_d[i] = ch_cnt_q[i] + CNT_W'(1);
              end
            end
          end
        end

        default: begin
          state_d = HOLD;
          cnt_d   = '0;
          ch_d    = '0;
          rel_d   = '0;
          held_d  = '0;
        end
      endcase
    end

    done_d = (state_d == RUN) && (held_d == '0);
  end

  always_ff @(posedge CLK) begin
    if (!SRSTn) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      ch_q     <= '0;
      held_q   <= '0;
      RSTn_OUT <= '0;
      RST_OUT  <= '1;
      BUSY     <= 1'b1;
      DONE     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_cnt_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ch_q     <= ch_d;
      held_q   <= held_d;
      RSTn_OUT <= rel_d;
      RST_OUT  <= ~rel_d;
      BUSY     <= ~done_d;
      DONE     <= done_d;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_cnt_q[i] <= ch_cnt_d[i];
      end
    end
  end

  // Free-running divider; only the board reset restarts it.
  always_ff @(posedge CLK) begin
    if (!SRSTn) begin
      div_q <= '0;
      TICK  <= 1'b0;
    end else begin
      TICK  <= (div_q == DIV_M1);
      div_q <= (div_q == DIV_M1) ? '0 : div_q + DIV_W'(1);
    end
  end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: directed plan steps then random traffic,
// checked against an edge-count model on two parameter sets.
module tb_rst_seq_gen;

  logic       CLK;
  logic       SRSTn;
  logic       SW;
  logic [3:0] CH;

  logic [3:0] rsn0, rs0, rsn1, rs1;
  logic       busy0, done0, tick0;
  logic       busy1, done1, tick1;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  rst_seq_gen dut0 (
    .CLK        (CLK),
    .SRSTn      (SRSTn),
    .SW_RST_REQ (SW),
    .CH_RST_REQ (CH),
    .RSTn_OUT   (rsn0),
    .RST_OUT    (rs0),
    .BUSY       (busy0),
    .DONE       (done0),
    .TICK       (tick0)
  );

  rst_seq_gen #(
    .HOLD_CYCLES (3),
    .STAGGER     (0),
    .DIV         (1)
  ) dut1 (
    .CLK        (CLK),
    .SRSTn      (SRSTn),
    .SW_RST_REQ (SW),
    .CH_RST_REQ (CH),
    .RSTn_OUT   (rsn1),
    .RST_OUT    (rs1),
    .BUSY       (busy1),
    .DONE       (done1),
    .TICK       (tick1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: e = edges since reset release, seq_base = edge the
  // current sequence started at, ch_until = re-reset end edge.
  bit in_rst;
  int e;
  int seq_base;
  int ch_until [2][4];

  function automatic int hp(input int d);
    return (d == 0) ? 16 : 3;
  endfunction

  function automatic int sp(input int d);
    return (d == 0) ? 4 : 0;
  endfunction

  function automatic int dp(input int d);
    return (d == 0) ? 10 : 1;
  endfunction

  function automatic int t_last(input int d);
    return hp(d) + 3 * sp(d);
  endfunction

  task automatic model_edge(input logic rst, input logic sw,
                            input logic [3:0] ch);
    if (!rst) begin
      in_rst   = 1'b1;
      e        = 0;
      seq_base = 0;
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < 4; k++) ch_until[d][k] = 0;
    end else begin
      in_rst = 1'b0;
      e      = e + 1;
      for (int d = 0; d < 2; d++) begin
        bit run_before;
        run_before = (e - 1 - seq_base) >= t_last(d);
        for (int k = 0; k < 4; k++) begin
          if (sw) ch_until[d][k] = 0;
          else if (run_before && ch[k]) ch_until[d][k] = e + hp(d);
        end
      end
      if (sw) seq_base = e;
    end
  endtask

  function automatic logic [3:0] exp_rsn(input int d);
    logic [3:0] r;
    r = '0;
    if (!in_rst)
      for (int k = 0; k < 4; k++)
        r[k] = ((e - seq_base) >= hp(d) + k * sp(d))
               && (e >= ch_until[d][k]);
    return r;
  endfunction

  function automatic logic exp_done(input int d);
    logic ok;
    if (in_rst) return 1'b0;
    ok = (e - seq_base) >= t_last(d);
    for (int k = 0; k < 4; k++)
      if (ch_until[d][k] > e) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic exp_tick(input int d);
    if (in_rst) return 1'b0;
    return (e % dp(d)) == 0;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s edge=%0d obs=%h exp=%h", tag, e, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rsn0", rsn0, exp_rsn(0));
    chk("rst0", rs0, ~exp_rsn(0));
    chk("done0", {3'b0, done0}, {3'b0, exp_done(0)});
    chk("busy0", {3'b0, busy0}, {3'b0, ~exp_done(0)});
    chk("tick0", {3'b0, tick0}, {3'b0, exp_tick(0)});
    chk("rsn1", rsn1, exp_rsn(1));
    chk("rst1", rs1, ~exp_rsn(1));
    chk("done1", {3'b0, done1}, {3'b0, exp_done(1)});
    chk("busy1", {3'b0, busy1}, {3'b0, ~exp_done(1)});
    chk("tick1", {3'b0, tick1}, {3'b0, exp_tick(1)});
  endtask

  task automatic step(input logic rst, input logic sw,
                      input logic [3:0] ch);
    SRSTn = rst;
    SW    = sw;
    CH    = ch;
    @(posedge CLK);
    model_edge(rst, sw, ch);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'b0);
  endtask

  task automatic hold_rst(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'b0);
  endtask

  initial begin
    SRSTn = 1'b0;
    SW    = 1'b0;
    CH    = 4'b0;
    in_rst   = 1'b1;
    e        = 0;
    seq_base = 0;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++) ch_until[d][k] = 0;

    // Power-up sequence.
    hold_rst(5);
    idle(40);

    // Channel 2 re-reset at edge 41, repeated at edge 51.
    step(1'b1, 1'b0, 4'b0100);
    idle(9);
    step(1'b1, 1'b0, 4'b0100);
    idle(20);

    // SW request with CH request at edge 22, during release.
    hold_rst(2);
    idle(21);
    step(1'b1, 1'b1, 4'b0001);
    idle(40);

    // One-cycle board reset at edge 18.
    hold_rst(2);
    idle(17);
    hold_rst(1);
    idle(40);

    // Tick spacing across a SW request at edge 36.
    hold_rst(2);
    idle(35);
    step(1'b1, 1'b1, 4'b0);
    idle(70);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic       r, s;
      logic [3:0] c;
      r = ($urandom_range(0, 199) != 0);
      s = ($urandom_range(0, 79) == 0);
      c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
      step(r, s, c);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rst_seq_gen.md
Name: rst_seq_gen

Overview:
- Synthesizable, parametrised successor to the bench clock/reset source.
- Takes the board-level synchronous active-low reset and produces NUM_CH staggered channel resets, each available in both polarities, for the router sub-blocks.
- Adds a software re-sequence request, per-channel re-reset, status flags and a divided clock-enable tick.

Parameters:
- NUM_CH, 4: number of reset channels.
- HOLD_CYCLES, 16: cycles that reset is held after the reset source is released; must be >= 1.
- STAGGER, 4: cycles between release of channel k-1 and channel k; 0 means all channels release together.
- CNT_W, 8: sequence counter width.
  - Elaboration error unless 2^CNT_W > HOLD_CYCLES + (NUM_CH-1)*STAGGER.
- DIV, 10: TICK period in cycles; must be >= 1.

Ports:
- CLK, in, 1: single clock; all logic on posedge.
- SRSTn, in, 1: synchronous active-low reset; sampled on posedge CLK only.
- SW_RST_REQ, in, 1: one-cycle pulse; re-runs the full sequence.
- CH_RST_REQ, in, NUM_CH: one-cycle pulse per bit; re-resets that channel only.
- RSTn_OUT, out, NUM_CH: channel resets, active-low, registered.
- RST_OUT, out, NUM_CH: exact complement of RSTn_OUT, registered.
- BUSY, out, 1: sequence or any channel re-reset in progress.
- DONE, out, 1: all channels released and no re-reset pending.
- TICK, out, 1: one-cycle clock-enable pulse every DIV cycles.

Behaviour:
- Interface: one clock CLK; reset SRSTn is synchronous and active-low. No asynchronous paths. All outputs are registered.
- While SRSTn is sampled low:
  - state = HOLD, sequence counter = 0, per-channel counters = 0, divider = 0.
  - RSTn_OUT = all 0, RST_OUT = all 1, BUSY = 1, DONE = 0, TICK = 0.
- Edge numbering: edge 1 is the first posedge with SRSTn sampled high.
- FSM states:
  - HOLD: counter increments each edge. At edge HOLD_CYCLES, go to RELEASE, set RSTn_OUT[0] to 1 and reset the counter.
  - RELEASE: RSTn_OUT[k] rises at edge HOLD_CYCLES + k*STAGGER. At the edge that releases channel NUM_CH-1, go to RUN; DONE rises and BUSY falls on that same edge.
  - STAGGER = 0: all channels rise at edge HOLD_CYCLES, and the FSM goes directly to RUN.
  - NUM_CH = 1: channel 0 release goes directly to RUN.
  - RUN: steady state; channels stay released unless re-reset.
- SW_RST_REQ:
  - In any state: next edge gives state = HOLD, counter = 0, all channels asserted, all channel re-resets cancelled, DONE = 0, BUSY = 1.
  - In HOLD: restarts the hold count.
- CH_RST_REQ[k]:
  - Honoured only in RUN; ignored in HOLD and RELEASE.
  - Next edge: RSTn_OUT[k] = 0, DONE = 0, BUSY = 1. Channel k is held for HOLD_CYCLES edges, then released.
  - No stagger applies. Other channels are unaffected.
  - Repeated request while channel k is held restarts its count.
- Simultaneous events:
  - SRSTn low overrides everything.
  - SW_RST_REQ overrides CH_RST_REQ.
  - Multiple CH_RST_REQ bits in one cycle run independently in parallel.
- Status flags:
  - DONE = (state == RUN) and no channel held by re-reset.
  - BUSY = not DONE, at all times after reset.
- TICK:
  - Free-running divider 0..DIV-1 counting from edge 1.
  - TICK = 1 at edges DIV, 2*DIV, and so on. DIV = 1 gives TICK = 1 at every edge from edge 1.
  - Unaffected by SW_RST_REQ and CH_RST_REQ; cleared only by SRSTn.
- Reset mid-sequence: SRSTn low during HOLD, RELEASE or RUN takes effect at the next edge, with reset values as above. Sequencing restarts from edge 1.

Test Plan:
- Defaults, SRSTn low for 5 cycles then high → RSTn_OUT rises per channel at edges 16, 20, 24 and 28; DONE = 1 and BUSY = 0 at edge 28; RST_OUT equals ~RSTn_OUT every cycle.
- STAGGER = 0, HOLD_CYCLES = 3 → all RSTn_OUT go 0xF at edge 3, DONE = 1 at edge 3.
- In RUN, pulse CH_RST_REQ = 4'b0100 at cycle 40 → RSTn_OUT = 4'b1011 from edge 41 through edge 56 and 4'b1111 at edge 57; DONE = 0 for edges 41 to 56; repeat pulse at cycle 50 extends the release to edge 67.
- SW_RST_REQ together with CH_RST_REQ = 4'b0001 during RELEASE (at edge 21) → RSTn_OUT = 0 at edge 22, full sequence re-runs with channel 0 rising 16 edges later; CH request has no effect.
- SRSTn low for 1 cycle at edge 18 → all outputs return to reset values at edge 19; TICK count restarts, first TICK 10 edges after SRSTn returns high.
- DIV = 10 over 100 cycles in RUN, with SW_RST_REQ at cycle 35 → TICK exactly at edges 10, 20, …, 100; spacing unaffected by the request.
